ecc_enc_pipe: RTL
=================

ECC_ENC_PIPE -- requirements
Module: ecc_enc_pipe

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: the source presents a data word.
REQ-004 SHALL have port in_data, input, 32 bits: the data word to encode.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-006 SHALL have port out_valid, output, 1 bit: out_code holds a valid codeword.
REQ-007 SHALL have port out_code, output, 40 bits: the codeword.
REQ-008 SHALL have port out_ready, input, 1 bit: the sink consumes out_code this cycle.
REQ-009 SHALL have port inj_arm, input, 1 bit: single-cycle pulse that arms error injection.
REQ-010 SHALL have port inj_mask, input, 40 bits: error pattern, sampled when inj_arm=1.
REQ-011 SHALL have port inj_pending, output, 1 bit: an armed mask is waiting for the next accepted word.
REQ-012 SHALL have port word_cnt, output, 16 bits: count of accepted words.

Function
REQ-013 SHALL treat a word as accepted when in_valid=1 and in_ready=1 at a clk edge, and as delivered when out_valid=1 and out_ready=1.
REQ-014 SHALL drive in_ready = !out_valid || out_ready, combinationally; no combinational path from in_valid to out_valid.
REQ-015 SHALL register the codeword of an accepted word into out_code and set out_valid on the same edge, giving 1-cycle latency and full throughput while out_ready=1.
REQ-016 SHALL clear out_valid on delivery without a new acceptance, and hold out_code/out_valid stable while out_valid=1 and out_ready=0.
REQ-017 SHALL form codeword bits [31:0] = in_data and bits [38:32] = C[6:0], where each C[i] is the XOR of the listed in_data bits:
 C0: 0,1,2,3,4,5,6,7,8,13,17,26,27,29
 C1: 0,1,2,3,4,12,16,18,21,22,23,24,25,28
 C2: 0,5,6,7,8,11,15,18,19,21,22,30,31
 C3: 1,5,10,14,18,19,20,23,24,26,27,28,29,30
 C4: 2,6,9,14,15,16,17,19,20,21,23,25,29,31
 C5: 3,7,9,10,11,12,13,20,22,24,25,27,31
 C6: 4,8,9,10,11,12,13,14,15,16,17,26,28,30
REQ-018 SHALL set codeword bit 39 to the XOR of codeword bits [38:0], so that all 40 bits have even parity.
REQ-019 SHALL, on the edge where inj_arm=1, latch inj_mask and set inj_pending=1; a new inj_arm while pending SHALL replace the latched mask.
REQ-020 SHALL XOR the latched mask into the codeword of the next accepted word after computing bit 39, and SHALL clear inj_pending on that edge.
REQ-021 SHALL, if inj_arm and an acceptance occur on the same edge, apply the old latched mask (if pending) to the current word and leave the new mask pending; with nothing pending, the current word passes clean and the new mask is pending.
REQ-022 SHALL increment word_cnt by 1 per accepted word and saturate at 0xFFFF.

Reset
REQ-023 SHALL, while rst_n=0, force out_valid=0, out_code=0, inj_pending=0, latched mask=0 and word_cnt=0, independent of clk.
REQ-024 SHALL drop a word in flight at reset assertion, and SHALL accept normally on the first clk edge after rst_n deasserts.

Verification
REQ-025 SHALL pass: in_data 0x00000000 -> out_code 0x0000000000 one cycle later; in_data 0x00000001 -> 0x0700000001.
REQ-026 SHALL pass: in_data 0xFFFFFFFF -> out_code 0x24FFFFFFFF; in_data 0x00000200 -> 0x7000000200.
REQ-027 SHALL pass: out_ready held at 0 for 3 cycles with in_valid=1 -> in_ready=0, out_code stable; out_ready=1 -> next word follows back-to-back.
REQ-028 SHALL pass: inj_arm with mask 0x0000000001, then send 0x00000001 -> 0x0700000000, inj_pending 1->0; the next word is clean.
REQ-029 SHALL pass: 65540 accepted words -> word_cnt=0xFFFF; rst_n pulsed mid-stall -> all outputs 0 immediately.
REQ-030 SHALL pass: random data, no injection -> out_code[38:32] and out_code[39] match the REQ-017 and REQ-018 functions.

Source files
------------

// File: rtl/ecc_enc_pipe.sv
// ecc_enc_pipe: single-stage pipelined (39,32) Hsiao-style SEC-DED encoder
// with an overall even-parity bit (bit 39) and one-shot error injection.
// The codeword is registered, so latency is one cycle. A ready/valid
// handshake on both sides sustains full throughput while the sink is ready.
module ecc_enc_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [39:0] out_code,
    input  logic        out_ready,
    input  logic        inj_arm,
    input  logic [39:0] inj_mask,
    output logic        inj_pending,
    output logic [15:0] word_cnt
);

    // Seven check bits, each the XOR of a fixed subset of the data bits.
    function automatic logic [6:0] calc_check(input logic [31:0] d);
        logic [6:0] c;
        c[0] = d[0] ^ d[1] ^ d[2] ^ d[3] ^ d[4] ^ d[5] ^ d[6] ^ d[7]
             ^ d[8] ^ d[13] ^ d[17] ^ d[26] ^ d[27] ^ d[29];
        c[1] = d[0] ^ d[1] ^ d[2] ^ d[3] ^ d[4] ^ d[12] ^ d[16] ^ d[18]
             ^ d[21] ^ d[22] ^ d[23] ^ d[24] ^ d[25] ^ d[28];
        c[2] = d[0] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[11] ^ d[15] ^ d[18]
             ^ d[19] ^ d[21] ^ d[22] ^ d[30] ^ d[31];
        c[3] = d[1] ^ d[5] ^ d[10] ^ d[14] ^ d[18] ^ d[19] ^ d[20] ^ d[23]
             ^ d[24] ^ d[26] ^ d[27] ^ d[28] ^ d[29] ^ d[30];
        c[4] = d[2] ^ d[6] ^ d[9] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[19]
             ^ d[20] ^ d[21] ^ d[23] ^ d[25] ^ d[29] ^ d[31];
        c[5] = d[3] ^ d[7] ^ d[9] ^ d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[20]
             ^ d[22] ^ d[24] ^ d[25] ^ d[27] ^ d[31];
        c[6] = d[4] ^ d[8] ^ d[9] ^ d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14]
             ^ d[15] ^ d[16] ^ d[17] ^ d[26] ^ d[28] ^ d[30];
        return c;
    endfunction

    // Overall parity bit that makes the full 40-bit word even.
    function automatic logic even_parity39(input logic [38:0] v);
        return ^v;
    endfunction

    // Clean 40-bit codeword for a data word (before any injection).
    function automatic logic [39:0] encode(input logic [31:0] d);
        logic [38:0] low;
        low = {calc_check(d), d};
        return {even_parity39(low), low};
    endfunction

    logic        out_valid_r;
    logic [39:0] out_code_r;
    logic        inj_pending_r;
    logic [39:0] inj_mask_r;
    logic [15:0] word_cnt_r;

    logic        in_ready_s;
    logic        accept_s;
    logic [39:0] code_s;

    assign in_ready_s = (!out_valid_r) || out_ready;
    assign accept_s   = in_valid && in_ready_s;

    // Next codeword: clean encoding, with the pending mask folded in after
    // the parity bit so injected errors really do break the code.
    always_comb begin
        code_s = encode(in_data);
        if (inj_pending_r) begin
            code_s = code_s ^ inj_mask_r;
        end else begin
            code_s = code_s;
        end
    end

    // Output register: load on acceptance, drop valid on a bare delivery,
    // otherwise hold (covers the stalled case).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_code_r  <= 40'h00_0000_0000;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_code_r  <= code_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Injection arming: a new arm always wins (replaces the mask and stays
    // pending); otherwise an acceptance consumes the pending mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_pending_r <= 1'b0;
            inj_mask_r    <= 40'h00_0000_0000;
        end else if (inj_arm) begin
            inj_pending_r <= 1'b1;
            inj_mask_r    <= inj_mask;
        end else if (accept_s) begin
            inj_pending_r <= 1'b0;
        end
    end

    // Saturating count of accepted words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_r <= 16'h0000;
        end else if (accept_s && (word_cnt_r != 16'hFFFF)) begin
            word_cnt_r <= word_cnt_r + 16'h0001;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign out_code    = out_code_r;
    assign inj_pending = inj_pending_r;
    assign word_cnt    = word_cnt_r;

endmodule
